// File: rtl/tempo_controller.sv
// Tempo front end for the metronome: synchronises and debounces the tempo controls, tracks bpm,
// and recomputes the beat period and BCD digits with a sequential divider and a double-dabble converter.
module tempo_controller #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned BPM_MIN         = 40,
  parameter int unsigned BPM_MAX         = 240,
  parameter int unsigned BPM_DEFAULT     = 120,
  parameter int unsigned BPM_STEP        = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] in,
  input  logic        tapup,
  input  logic        tapdown,
  output logic [7:0]  bpm,
  output logic [3:0]  hex100,
  output logic [3:0]  hex10,
  output logic [3:0]  hex0,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        period_update
);

  localparam int unsigned DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [63:0] DIVIDEND_W = 64'(CLK_HZ) * 64'd60;
  localparam logic [31:0] DIVIDEND   = DIVIDEND_W[31:0];
  localparam logic [31:0] PERIOD_RST = 32'(DIVIDEND_W / 64'(BPM_DEFAULT));
  localparam logic [3:0]  RST_H      = 4'((BPM_DEFAULT / 100) % 10);
  localparam logic [3:0]  RST_T      = 4'((BPM_DEFAULT / 10) % 10);
  localparam logic [3:0]  RST_U      = 4'(BPM_DEFAULT % 10);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_BCD, S_COMMIT} state_t;

  state_t state, state_next;

  logic [1:0]  key_m, key_s;
  logic [17:0] in_m, in_s;
  logic [1:0]  db_level;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]  press;

  logic        code_valid, prev_valid, preset_load;
  logic [4:0]  code_idx, prev_idx;
  logic [8:0]  preset_raw;
  logic [7:0]  preset_bpm;
  logic [7:0]  bpm_next;
  logic        bpm_changed;

  logic [7:0]  divisor, rem, rem_n;
  logic [31:0] dividend, quo;
  logic [8:0]  trial;
  logic        q_bit;
  logic [4:0]  it_cnt;
  logic [19:0] bcd_sr, bcd_adj, bcd_step;

  // Two-flop synchronisers; keys idle high, presets idle low so reset never looks like a preset change
  always_ff @(posedge clock) begin
    if (reset) begin
      key_m <= 2'b11;
      key_s <= 2'b11;
      in_m  <= '0;
      in_s  <= '0;
    end else begin
      key_m <= {tapdown, tapup};
      key_s <= key_m;
      in_m  <= in;
      in_s  <= in_m;
    end
  end

  // Per-key debouncer: level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      db_level <= 2'b11;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (key_s[k] == db_level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_cnt[k]   <= '0;
          db_level[k] <= key_s[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Press pulse coincides with the debounced 1->0 flip; index 0 is up, 1 is down
  always_comb begin
    press = '0;
    for (int k = 0; k < 2; k++)
      press[k] = db_level[k] & ~key_s[k] & (db_cnt[k] == DB_LAST);
  end

  always_comb begin
    code_valid = 1'b0;
    code_idx   = '0;
    for (int i = 17; i >= 0; i--) begin
      if (in_s[i]) begin
        code_valid = 1'b1;
        code_idx   = 5'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_valid <= 1'b0;
      prev_idx   <= '0;
    end else begin
      prev_valid <= code_valid;
      prev_idx   <= code_idx;
    end
  end

  always_comb begin
    preset_load = code_valid & (~prev_valid | (prev_idx != code_idx));
    preset_raw  = 9'd60 + 9'(code_idx) * 9'd10;
    if (preset_raw > 9'(BPM_MAX))      preset_bpm = 8'(BPM_MAX);
    else if (preset_raw < 9'(BPM_MIN)) preset_bpm = 8'(BPM_MIN);
    else                               preset_bpm = preset_raw[7:0];
  end

  // Tempo update: preset beats keys, simultaneous up/down cancels
  always_comb begin
    bpm_next = bpm;
    if (preset_load) begin
      bpm_next = preset_bpm;
    end else if (press[0] && !press[1]) begin
      if ({1'b0, bpm} + 9'(BPM_STEP) > 9'(BPM_MAX)) bpm_next = 8'(BPM_MAX);
      else                                          bpm_next = bpm + 8'(BPM_STEP);
    end else if (press[1] && !press[0]) begin
      if ({1'b0, bpm} < 9'(BPM_MIN) + 9'(BPM_STEP)) bpm_next = 8'(BPM_MIN);
      else                                          bpm_next = bpm - 8'(BPM_STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A pending bpm change restarts the pipeline from any state
  always_comb begin
    state_next = state;
    if (bpm_changed) begin
      state_next = S_DIV;
    end else begin
      case (state)
        S_IDLE:   state_next = S_IDLE;
        S_DIV:    if (it_cnt == 5'd31) state_next = S_BCD;
        S_BCD:    if (it_cnt == 5'd7)  state_next = S_COMMIT;
        S_COMMIT: state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // One restoring-division step; remainder always stays below the 8-bit divisor
  always_comb begin
    trial = {rem, dividend[31]};
    q_bit = (trial >= {1'b0, divisor});
    rem_n = q_bit ? 8'(trial - {1'b0, divisor}) : trial[7:0];
  end

  // One double-dabble step over three BCD digits above the 8-bit binary field
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < 3; d++) begin
      if (bcd_adj[8 + 4*d +: 4] >= 4'd5)
        bcd_adj[8 + 4*d +: 4] = bcd_adj[8 + 4*d +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[18:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bpm           <= 8'(BPM_DEFAULT);
      bpm_changed   <= 1'b0;
      divisor       <= 8'(BPM_DEFAULT);
      rem           <= '0;
      quo           <= '0;
      dividend      <= '0;
      it_cnt        <= '0;
      bcd_sr        <= '0;
      period        <= PERIOD_RST;
      hex100        <= RST_H;
      hex10         <= RST_T;
      hex0          <= RST_U;
      period_valid  <= 1'b1;
      period_update <= 1'b0;
    end else begin
      bpm           <= bpm_next;
      bpm_changed   <= (bpm_next != bpm);
      period_update <= 1'b0;
      if (bpm_changed) begin
        divisor      <= bpm;
        rem          <= '0;
        quo          <= '0;
        dividend     <= DIVIDEND;
        it_cnt       <= '0;
        period_valid <= 1'b0;
      end else begin
        case (state)
          S_DIV: begin
            rem      <= rem_n;
            quo      <= {quo[30:0], q_bit};
            dividend <= {dividend[30:0], 1'b0};
            it_cnt   <= it_cnt + 5'd1;
            if (it_cnt == 5'd31) bcd_sr <= {12'd0, divisor};
          end
          S_BCD: begin
            bcd_sr <= bcd_step;
            it_cnt <= it_cnt + 5'd1;
          end
          S_COMMIT: begin
            period        <= quo;
            hex100        <= bcd_sr[19:16];
            hex10         <= bcd_sr[15:12];
            hex0          <= bcd_sr[11:8];
            period_valid  <= 1'b1;
            period_update <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tempo_controller.sv
// Directed bench for tempo_controller: expected commits are queued when stimulus is applied and
// checked against each period_update pulse, alongside direct checks of reset, latency and saturation.
module tb_tempo_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] in;
  logic        tapup, tapdown;
  logic [7:0]  bpm;
  logic [3:0]  hex100, hex10, hex0;
  logic [31:0] period;
  logic        period_valid, period_update;

  typedef struct {
    logic [31:0] period;
    logic [3:0]  h100;
    logic [3:0]  h10;
    logic [3:0]  h0;
    logic [7:0]  bpm;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;

  tempo_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in(in), .tapup(tapup), .tapdown(tapdown),
    .bpm(bpm), .hex100(hex100), .hex10(hex10), .hex0(hex0),
    .period(period), .period_valid(period_valid), .period_update(period_update)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] u, input logic [7:0] b);
    exp_t e;
    e.period = p; e.h100 = h; e.h10 = t; e.h0 = u; e.bpm = b;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor: every commit pulse must match the oldest queued expectation
  initial begin
    int   chg_cyc;
    logic [7:0] last_bpm;
    exp_t e;
    chg_cyc  = 0;
    last_bpm = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (bpm !== last_bpm) chg_cyc = cyc;
        last_bpm = bpm;
        if (period_update === 1'b1) begin
          chk("sb_expected_commit", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_period", period, e.period);
            chk("sb_hex100", 32'(hex100), 32'(e.h100));
            chk("sb_hex10", 32'(hex10), 32'(e.h10));
            chk("sb_hex0", 32'(hex0), 32'(e.h0));
            chk("sb_bpm", 32'(bpm), 32'(e.bpm));
            chk("sb_valid", 32'(period_valid), 32'd1);
            chk("sb_latency", 32'(cyc - chg_cyc), 32'd42);
          end
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_bpm(input logic [7:0] want, input int bound, input string tag, output int n);
    n = 0;
    while (bpm !== want && n < bound) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(bpm), 32'(want));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (period_valid !== 1'b1 && n < 100);
    chk(tag, 32'(n), 32'd42);
    cyc_wait(2);
    chk({tag, "_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic wait_settle(input string tag);
    int n;
    n = 0;
    while (period_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(period_valid), 32'd1);
    cyc_wait(2);
    chk({tag, "_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic press(input logic up, input logic dn);
    tapup = ~up;
    tapdown = ~dn;
    cyc_wait(8);
    tapup = 1'b1;
    tapdown = 1'b1;
    cyc_wait(8);
  endtask

  task automatic press_watch(input logic up, input logic dn, output int drops);
    drops = 0;
    tapup = ~up;
    tapdown = ~dn;
    repeat (8) begin
      @(negedge clock);
      if (period_valid !== 1'b1) drops++;
    end
    tapup = 1'b1;
    tapdown = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (period_valid !== 1'b1) drops++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_bpm"}, 32'(bpm), 32'd120);
    chk({tag, "_hex100"}, 32'(hex100), 32'd1);
    chk({tag, "_hex10"}, 32'(hex10), 32'd2);
    chk({tag, "_hex0"}, 32'(hex0), 32'd0);
    chk({tag, "_period"}, period, 32'd25_000_000);
    chk({tag, "_valid"}, 32'(period_valid), 32'd1);
    chk({tag, "_update"}, 32'(period_update), 32'd0);
  endtask

  initial begin
    int n;
    int drops;
    int upd;
    reset = 1'b1;
    in = '0;
    tapup = 1'b1;
    tapdown = 1'b1;

    // Reset held for three cycles
    cyc_wait(3);
    reset = 1'b0;
    cyc_wait(1);
    check_reset_values("rst");
    mon_en = 1'b1;

    // Preset 0 -> 60 bpm, three cycles after the switch moves
    push_exp(32'd50_000_000, 4'd0, 4'd6, 4'd0, 8'd60);
    in[0] = 1'b1;
    wait_bpm(8'd60, 20, "p0_bpm", n);
    chk("p0_in_latency", 32'(n), 32'd3);
    wait_valid("p0_valid_latency");

    // Lowest set bit wins, then the next bit takes over
    in = '0;
    in[3] = 1'b1;
    in[17] = 1'b1;
    push_exp(32'd33_333_333, 4'd0, 4'd9, 4'd0, 8'd90);
    wait_bpm(8'd90, 20, "p3_bpm", n);
    wait_valid("p3_valid_latency");
    push_exp(32'd13_043_478, 4'd2, 4'd3, 4'd0, 8'd230);
    in[3] = 1'b0;
    wait_bpm(8'd230, 20, "p17_bpm", n);
    wait_valid("p17_valid_latency");

    // Back to default tempo, then a bouncy held tap-up
    in = '0;
    cyc_wait(4);
    reset = 1'b1;
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(1);
    chk("rst2_bpm", 32'(bpm), 32'd120);
    repeat (3) begin
      tapup = 1'b0;
      cyc_wait(2);
      tapup = 1'b1;
      cyc_wait(2);
    end
    chk("bounce_no_change", 32'(bpm), 32'd120);
    push_exp(32'd24_793_388, 4'd1, 4'd2, 4'd1, 8'd121);
    tapup = 1'b0;
    wait_bpm(8'd121, 20, "hold_bpm", n);
    wait_valid("hold_valid_latency");
    cyc_wait(50);
    chk("hold_no_repeat", 32'(bpm), 32'd121);
    tapup = 1'b1;
    cyc_wait(20);
    chk("release_no_change", 32'(bpm), 32'd121);

    // Second down press lands inside DIV; only 119 may be committed
    push_exp(32'd25_210_084, 4'd1, 4'd1, 4'd9, 8'd119);
    tapdown = 1'b0;
    wait_bpm(8'd120, 20, "abort_first_bpm", n);
    tapdown = 1'b1;
    cyc_wait(6);
    tapdown = 1'b0;
    wait_bpm(8'd119, 20, "abort_second_bpm", n);
    wait_valid("abort_valid_latency");
    tapdown = 1'b1;
    cyc_wait(10);

    // Upper saturation
    push_exp(32'd13_043_478, 4'd2, 4'd3, 4'd0, 8'd230);
    in[17] = 1'b1;
    wait_bpm(8'd230, 20, "p17b_bpm", n);
    wait_valid("p17b_valid_latency");
    push_exp(32'd12_500_000, 4'd2, 4'd4, 4'd0, 8'd240);
    repeat (10) press(1'b1, 1'b0);
    wait_settle("to240_settle");
    chk("to240_bpm", 32'(bpm), 32'd240);
    press_watch(1'b1, 1'b0, drops);
    chk("sat_hi_bpm", 32'(bpm), 32'd240);
    chk("sat_hi_no_drop", 32'(drops), 32'd0);

    // Lower saturation and simultaneous presses
    push_exp(32'd50_000_000, 4'd0, 4'd6, 4'd0, 8'd60);
    in[0] = 1'b1;
    wait_bpm(8'd60, 20, "p0b_bpm", n);
    wait_valid("p0b_valid_latency");
    push_exp(32'd75_000_000, 4'd0, 4'd4, 4'd0, 8'd40);
    repeat (20) press(1'b0, 1'b1);
    wait_settle("to40_settle");
    chk("to40_bpm", 32'(bpm), 32'd40);
    press_watch(1'b0, 1'b1, drops);
    chk("sat_lo_bpm", 32'(bpm), 32'd40);
    chk("sat_lo_no_drop", 32'(drops), 32'd0);
    press_watch(1'b1, 1'b1, drops);
    chk("both_bpm", 32'(bpm), 32'd40);
    chk("both_no_drop", 32'(drops), 32'd0);

    // Reset in the middle of BCD: no commit must follow
    in = '0;
    cyc_wait(4);
    tapup = 1'b0;
    wait_bpm(8'd41, 20, "pre_rst_bpm", n);
    cyc_wait(37);
    reset = 1'b1;
    cyc_wait(1);
    check_reset_values("midrst");
    reset = 1'b0;
    tapup = 1'b1;
    upd = 0;
    repeat (60) begin
      @(negedge clock);
      if (period_update === 1'b1) upd++;
    end
    chk("midrst_no_update", 32'(upd), 32'd0);
    chk("midrst_bpm_hold", 32'(bpm), 32'd120);
    chk("final_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
